// File: rtl/spmv_result_drain.sv
// Collects one SPMV result set into a row buffer, streams the nonzero rows out
// in ascending order under valid/ready, then emits a one-cycle argmax/count summary.
module spmv_result_drain (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [4:0]  in_row,
   input  logic [20:0] in_data,
   input  logic        in_finish,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_row,
   output logic [20:0] out_data,
   output logic        out_last,
   output logic        sum_valid,
   output logic [4:0]  max_row,
   output logic [20:0] max_data,
   output logic [5:0]  nz_count,
   output logic        busy
);

   typedef enum logic [1:0] {COLLECT, DRAIN, SUMMARY} state_t;

   state_t      state;
   logic [20:0] row_buf [32];
   logic [31:0] nz;
   logic [4:0]  cur_row;

   logic        accept;
   logic [31:0] eff_nz;
   logic [31:0] above;
   logic [4:0]  best_row;
   logic [20:0] best_data;
   logic [20:0] v;
   logic [5:0]  cnt;

   function automatic logic [4:0] lowest(input logic [31:0] m);
      logic [4:0] r;
      r = '0;
      for (int i = 31; i >= 0; i--)
         if (m[i]) r = 5'(i);
      return r;
   endfunction

   assign accept = (state == COLLECT) && (in_valid || in_finish);
   assign above  = nz & ((32'hFFFF_FFFF << cur_row) << 1);

   // Argmax and count are taken over the buffer as it will look after this edge,
   // so overwritten rows (including ones rewritten to zero) are judged by final value.
   always_comb begin
      eff_nz    = nz;
      best_row  = '0;
      best_data = '0;
      cnt       = '0;
      v         = '0;
      if (accept) eff_nz[in_row] = (in_data != 0);
      for (int i = 0; i < 32; i++) begin
         v = (accept && in_row == 5'(i)) ? in_data : row_buf[i];
         if (v > best_data) begin
            best_data = v;
            best_row  = 5'(i);
         end
         cnt = cnt + 6'(eff_nz[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= COLLECT;
         nz       <= '0;
         cur_row  <= '0;
         max_row  <= '0;
         max_data <= '0;
         nz_count <= '0;
         for (int i = 0; i < 32; i++) row_buf[i] <= '0;
      end else begin
         case (state)
            COLLECT: if (accept) begin
               row_buf[in_row] <= in_data;
               nz[in_row]      <= (in_data != 0);
               if (in_finish) begin
                  if (|eff_nz) begin
                     state   <= DRAIN;
                     cur_row <= lowest(eff_nz);
                  end else begin
                     state    <= SUMMARY;
                     max_row  <= best_row;
                     max_data <= best_data;
                     nz_count <= cnt;
                  end
               end
            end
            DRAIN: if (out_ready) begin
               if (above == '0) begin
                  state    <= SUMMARY;
                  max_row  <= best_row;
                  max_data <= best_data;
                  nz_count <= cnt;
               end else begin
                  cur_row <= lowest(above);
               end
            end
            default: begin
               state    <= COLLECT;
               nz       <= '0;
               cur_row  <= '0;
               max_row  <= '0;
               max_data <= '0;
               nz_count <= '0;
               for (int i = 0; i < 32; i++) row_buf[i] <= '0;
            end
         endcase
      end
   end

   assign out_valid = (state == DRAIN);
   assign out_row   = out_valid ? cur_row : '0;
   assign out_data  = out_valid ? row_buf[cur_row] : '0;
   assign out_last  = out_valid && (above == '0);
   assign sum_valid = (state == SUMMARY);
   assign busy      = (state != COLLECT);

endmodule

// File: doc/spmv_result_drain.md
SPMV_RESULT_DRAIN -- requirements
Module: spmv_result_drain

Interface
REQ-001 SHALL provide: clk  input  1  clock, all state on rising edge.
REQ-002 SHALL provide: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: in_valid  input  1  result beat valid from SPMV stage.
REQ-004 SHALL provide: in_row  input  5  row index of beat.
REQ-005 SHALL provide: in_data  input  21  row result value, unsigned.
REQ-006 SHALL provide: in_finish  input  1  final beat of a result set; carries valid row/data.
REQ-007 SHALL provide: out_valid  output  1  drained nonzero row present.
REQ-008 SHALL provide: out_ready  input  1  downstream accepts drained row.
REQ-009 SHALL provide: out_row  output  5  drained row index.
REQ-010 SHALL provide: out_data  output  21  drained row value.
REQ-011 SHALL provide: out_last  output  1  current drained row is last nonzero row.
REQ-012 SHALL provide: sum_valid  output  1  one-cycle summary pulse.
REQ-013 SHALL provide: max_row / max_data / nz_count  output  5 / 21 / 6  summary: argmax row, max value, count of nonzero rows (0..32).
REQ-014 SHALL provide: busy  output  1  high in DRAIN and SUMMARY; input beats ignored.

Function
REQ-015 States SHALL be COLLECT, DRAIN, SUMMARY; reset state COLLECT.
REQ-016 In COLLECT, a beat SHALL be accepted when (in_valid || in_finish); buf[in_row] <= in_data, nz[in_row] <= (in_data != 0).
REQ-017 A repeated row in one set SHALL overwrite buffer and nz flag; nz_count = popcount(nz) at summary.
REQ-018 Running max SHALL update when in_data > max_data, or in_data == max_data and in_row < max_row; all-zero set gives max_row=0, max_data=0.
REQ-019 Accepted beat with in_finish=1 SHALL move to DRAIN next cycle if any nz bit set after that beat, else to SUMMARY.
REQ-020 In DRAIN, out_valid SHALL be high every cycle; out_row = lowest nonzero row >= scan pointer, out_data = buf[out_row], pointer starts at 0.
REQ-021 Transfer SHALL occur on rising edge with out_valid && out_ready; next nonzero row presented the following cycle (no bubbles).
REQ-022 out_row/out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-023 out_last SHALL be high iff no nonzero row exists above out_row; transfer with out_last SHALL move to SUMMARY.
REQ-024 In SUMMARY (exactly one cycle), sum_valid SHALL be 1 with max_row, max_data, nz_count valid; next state COLLECT.
REQ-025 On SUMMARY exit, buf, nz, max_row, max_data SHALL clear to 0; beats accepted from the first COLLECT cycle.
REQ-026 Beats arriving while busy=1 SHALL be dropped with no state change.
REQ-027 Outside DRAIN, out_valid, out_last SHALL be 0; outside SUMMARY, sum_valid SHALL be 0.
REQ-028 Latency: first out_valid one cycle after finish-beat edge; sum_valid one cycle after last transfer.

Reset
REQ-029 rst_n low SHALL force COLLECT, clear buf, nz, max, pointer, and drive all outputs 0 immediately, including mid-DRAIN.
REQ-030 After rst_n release, first accepted beat SHALL be on first rising edge with beat asserted.

Verification
REQ-031 Rows 0..31 data=row*3, finish on row 31, out_ready=1 -> 31 transfers rows 1..31 back-to-back, out_last on row 31, sum: max_row=31, max_data=93, nz_count=31.
REQ-032 All 32 rows data=0 -> no out_valid; sum_valid one cycle after finish beat, nz_count=0, max_row=0, max_data=0.
REQ-033 Rows 4=100, 9=100, 20=7, rest 0, out_ready toggling 1/0 -> rows 4,9,20 each held until accepted, max_row=4, nz_count=3.
REQ-034 Row 5 written 50 then 0 in same set, row 6=1 -> only row 6 drained, nz_count=1, max_row=6, max_data=1.
REQ-035 Beats during DRAIN -> ignored; next set results unaffected.
REQ-036 rst_n pulsed low mid-DRAIN -> outputs 0 asynchronously; fresh set afterwards drains correctly.
